// File: rtl/cont_asc_bcd_pkg.sv
// cont_asc_bcd shared definitions:
// segment patterns and default terminal count.
package cont_asc_bcd_pkg;

  localparam int MAX_DEFAULT = 59;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/cont_asc_bcd_if.sv
// cont_asc_bcd control/display bundle:
// strobes in, BCD digits and segments out.
interface cont_asc_bcd_if;

  logic       TICK;
  logic       EN;
  logic       CLR;
  logic [3:0] UNI;
  logic [3:0] DEZ;
  logic       CARRY;
  logic [6:0] HEX0;
  logic [6:0] HEX1;

  modport master (
    output TICK, EN, CLR,
    input  UNI, DEZ, CARRY, HEX0, HEX1
  );

  modport slave (
    input  TICK, EN, CLR,
    output UNI, DEZ, CARRY, HEX0, HEX1
  );

endinterface

// File: rtl/decod_7seg.sv
// BCD digit to active-low seven-segment
// pattern, bit order gfedcba.
module decod_7seg
  import cont_asc_bcd_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [6:0] seg_o
);

  // pure table lookup; codes 10..15 blank
  always_comb begin
    seg_o = SEG_BLANK;
    case (d_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/cont_asc_bcd.sv
// Two-digit BCD up counter 00..MAX with
// wrap carry pulse and 7-seg displays.
module cont_asc_bcd
  import cont_asc_bcd_pkg::*;
#(
  parameter int MAX = MAX_DEFAULT
) (
  input  logic          CLK,
  input  logic          RST,
  cont_asc_bcd_if.slave bus
);

  localparam logic [3:0] MAX_DEZ = 4'(MAX / 10);
  localparam logic [3:0] MAX_UNI = 4'(MAX % 10);

  logic [3:0] uni_q;
  logic [3:0] uni_d;
  logic [3:0] dez_q;
  logic [3:0] dez_d;
  logic       carry_q;
  logic       carry_d;
  logic       adv;
  logic       at_max;

  assign adv    = bus.TICK & bus.EN;
  assign at_max = (dez_q == MAX_DEZ) &&
                  (uni_q == MAX_UNI);

  // next count: clear beats advance beats hold;
  // carry only on the MAX->00 wrap
  always_comb begin
    uni_d   = uni_q;
    dez_d   = dez_q;
    carry_d = 1'b0;
    if (bus.CLR) begin
      uni_d = 4'd0;
      dez_d = 4'd0;
    end else if (adv) begin
      if (at_max) begin
        uni_d   = 4'd0;
        dez_d   = 4'd0;
        carry_d = 1'b1;
      end else if (uni_q >= DIGIT_MAX) begin
        uni_d = 4'd0;
        dez_d = dez_q + 4'd1;
      end else begin
        uni_d = uni_q + 4'd1;
      end
    end
  end

  // digit and carry registers, sync reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      uni_q   <= 4'd0;
      dez_q   <= 4'd0;
      carry_q <= 1'b0;
    end else begin
      uni_q   <= uni_d;
      dez_q   <= dez_d;
      carry_q <= carry_d;
    end
  end

  assign bus.UNI   = uni_q;
  assign bus.DEZ   = dez_q;
  assign bus.CARRY = carry_q;

  decod_7seg u_hex0 (
    .d_i   (uni_q),
    .seg_o (bus.HEX0)
  );

  decod_7seg u_hex1 (
    .d_i   (dez_q),
    .seg_o (bus.HEX1)
  );

endmodule

// File: tb/tb_cont_asc_bcd.sv
// Directed bench for cont_asc_bcd:
// vector table plus multi-cycle sequences.
module tb_cont_asc_bcd;

  typedef struct {
    string    name;
    logic     rst;
    logic     clr;
    logic     tick;
    logic     en;
    int       dez;
    int       uni;
    int       carry;
  } vec_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  cont_asc_bcd_if if59 ();
  cont_asc_bcd_if if99 ();

  cont_asc_bcd #(.MAX(59)) u_dut59 (
    .CLK (CLK),
    .RST (RST),
    .bus (if59)
  );

  cont_asc_bcd #(.MAX(99)) u_dut99 (
    .CLK (CLK),
    .RST (RST),
    .bus (if99)
  );

  logic [3:0] dec_in;
  logic [6:0] dec_out;

  decod_7seg u_dec (
    .d_i   (dec_in),
    .seg_o (dec_out)
  );

  always #5 CLK = ~CLK;

  int pass_cnt = 0;
  int total = 0;
  logic [6:0] segtab [16];
  vec_t vecs[$];

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    total++;
    if (act !== exp)
      $display("FAIL %s actual=%0d required=%0d",
               nm, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic step(input logic rst,
                      input logic clr,
                      input logic tick,
                      input logic en);
    @(negedge CLK);
    RST = rst;
    if59.CLR = clr;
    if59.TICK = tick;
    if59.EN = en;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk59(input string nm,
                       input int dez,
                       input int uni,
                       input int carry);
    chk({nm, "_dez"}, int'(if59.DEZ), dez);
    chk({nm, "_uni"}, int'(if59.UNI), uni);
    chk({nm, "_carry"}, int'(if59.CARRY), carry);
    chk({nm, "_hex0"}, int'(if59.HEX0),
        int'(segtab[uni]));
    chk({nm, "_hex1"}, int'(if59.HEX1),
        int'(segtab[dez]));
  endtask

  task automatic ticks59(input int n,
                         output int carries);
    carries = 0;
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1);
      if (if59.CARRY === 1'b1) carries++;
    end
  endtask

  initial begin
    int c;
    int bad;
    int div;
    int pulses;
    logic t;

    segtab[0]  = 7'b1000000;
    segtab[1]  = 7'b1111001;
    segtab[2]  = 7'b0100100;
    segtab[3]  = 7'b0110000;
    segtab[4]  = 7'b0011001;
    segtab[5]  = 7'b0010010;
    segtab[6]  = 7'b0000010;
    segtab[7]  = 7'b1111000;
    segtab[8]  = 7'b0000000;
    segtab[9]  = 7'b0010000;
    for (int i = 10; i < 16; i++)
      segtab[i] = 7'b1111111;

    vecs.push_back('{"rst", 1,0,0,0, 0,0,0});
    for (int i = 1; i <= 10; i++)
      vecs.push_back('{$sformatf("tick%0d", i),
                       0,0,1,1, i/10, i%10, 0});
    vecs.push_back('{"idle", 0,0,0,1, 1,0,0});
    vecs.push_back('{"en0", 0,0,1,0, 1,0,0});
    vecs.push_back('{"tick11", 0,0,1,1, 1,1,0});
    vecs.push_back('{"clrtick", 0,1,1,1, 0,0,0});
    vecs.push_back('{"tick1b", 0,0,1,1, 0,1,0});
    vecs.push_back('{"rstall", 1,1,1,1, 0,0,0});

    if59.CLR = 1'b0;
    if59.TICK = 1'b0;
    if59.EN = 1'b0;
    if99.CLR = 1'b0;
    if99.TICK = 1'b0;
    if99.EN = 1'b0;
    dec_in = 4'd0;

    for (int d = 0; d < 16; d++) begin
      dec_in = 4'(d);
      #1;
      chk($sformatf("dec%0d", d),
          int'(dec_out), int'(segtab[d]));
    end

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].clr,
           vecs[i].tick, vecs[i].en);
      chk59(vecs[i].name, vecs[i].dez,
            vecs[i].uni, vecs[i].carry);
    end

    ticks59(58, c);
    chk59("pre58", 5, 8, 0);
    chk("pre58_nocarry", c, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk59("at59", 5, 9, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk59("wrap", 0, 0, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk59("wrap_after", 0, 0, 0);

    ticks59(23, c);
    chk59("at23", 2, 3, 0);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 1'b1, 1'b0);
    chk59("paused", 2, 3, 0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b1, 1'b1);
    chk59("held3", 2, 6, 0);

    ticks59(33, c);
    chk59("to59", 5, 9, 0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk59("clr_at_max", 0, 0, 0);
    ticks59(37, c);
    chk59("at37", 3, 7, 0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk59("rstclr37", 0, 0, 0);

    div = 0;
    pulses = 0;
    for (int i = 0; i < 150; i++) begin
      t = (div == 49);
      div = (div == 49) ? 0 : div + 1;
      if (t) pulses++;
      step(1'b0, 1'b0, t, 1'b1);
    end
    chk("div_pulses", pulses, 3);
    chk59("div3s", 0, 3, 0);

    bad = 0;
    c = 0;
    for (int i = 0; i < 99; i++) begin
      @(negedge CLK);
      if99.TICK = 1'b1;
      if99.EN = 1'b1;
      @(posedge CLK);
      #1;
      if (if99.UNI > 4'd9 || if99.DEZ > 4'd9)
        bad++;
      if (if99.CARRY === 1'b1) c++;
    end
    chk("m99_bcd", bad, 0);
    chk("m99_nocarry", c, 0);
    chk("m99_dez", int'(if99.DEZ), 9);
    chk("m99_uni", int'(if99.UNI), 9);
    chk("m99_hex1", int'(if99.HEX1),
        int'(segtab[9]));
    @(negedge CLK);
    @(posedge CLK);
    #1;
    chk("m99_wrap_dez", int'(if99.DEZ), 0);
    chk("m99_wrap_uni", int'(if99.UNI), 0);
    chk("m99_wrap_carry", int'(if99.CARRY), 1);
    @(negedge CLK);
    if99.TICK = 1'b0;
    @(posedge CLK);
    #1;
    chk("m99_after_carry", int'(if99.CARRY), 0);
    chk("m99_after_uni", int'(if99.UNI), 0);

    $display("%0d/%0d checks passed",
             pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/cont_asc_bcd.md
CONT_ASC_BCD -- requirements
Module: cont_asc_bcd

Interface
REQ-001 Parameter MAX, default 59, is the terminal count in decimal; legal range 1..99.
REQ-002 Port CLK, input, 1, sole clock; all state updates on its rising edge.
REQ-003 Port RST, input, 1, reset; synchronous, active-high.
REQ-004 Port TICK, input, 1, count-advance strobe from the 1 Hz frequency divider; normally high for one CLK cycle per second.
REQ-005 Port EN, input, 1, count enable; 0 = pause, count held.
REQ-006 Port CLR, input, 1, synchronous clear to 00; active-high.
REQ-007 Port UNI, output, 4, BCD units digit, registered.
REQ-008 Port DEZ, output, 4, BCD tens digit, registered.
REQ-009 Port CARRY, output, 1, single-cycle pulse on wrap MAX->00, registered.
REQ-010 Port HEX0, output, 7, seven-segment pattern for UNI; active-low; bit order gfedcba.
REQ-011 Port HEX1, output, 7, seven-segment pattern for DEZ; same encoding as HEX0.

Function
REQ-012 Per-edge priority SHALL be: RST > CLR > (TICK & EN) > hold.
REQ-013 On a CLR edge, UNI and DEZ SHALL become 0 and CARRY SHALL become 0.
REQ-014 On a TICK & EN edge with count != MAX: if UNI < 9, UNI increments by 1 and DEZ is held; if UNI == 9, UNI becomes 0 and DEZ increments by 1.
REQ-015 On a TICK & EN edge with count == MAX (DEZ*10+UNI): UNI and DEZ SHALL become 0 and CARRY SHALL be 1 for exactly that following cycle.
REQ-016 CARRY SHALL be 0 on every edge that does not perform the wrap in REQ-015, including hold, CLR and RST edges.
REQ-017 Latency: UNI and DEZ SHALL reflect an accepted TICK on the edge that samples it (1 cycle).
REQ-018 TICK is level-sampled: a TICK held high for N cycles with EN=1 SHALL advance the count N times.
REQ-019 With EN=0, TICK SHALL be ignored; count and CARRY behave as hold.
REQ-020 CLR coincident with TICK & EN at count MAX SHALL give 00 with CARRY=0.
REQ-021 Count values above MAX or non-BCD digit values SHALL never appear on UNI/DEZ after the first reset.
REQ-022 HEX0 and HEX1 SHALL be combinational decodes of the registered UNI/DEZ, with zero added latency.
REQ-023 Segment patterns SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-024 Digit codes 10..15 SHALL decode to 1111111 (all segments off).

Reset
REQ-025 On a RST edge: UNI=0, DEZ=0, CARRY=0, hence HEX0=HEX1=1000000.
REQ-026 RST asserted mid-count SHALL discard the count on that edge, independent of TICK, EN and CLR.
REQ-027 Before the first RST edge, output values are unspecified; the bench SHALL not check them.

Structure
REQ-028 The shared package SHALL hold the ten segment-pattern constants, the blank pattern, and the MAX default.
REQ-029 The decode SHALL be one sub-module, decod_7seg (4-bit in, 7-bit out), instantiated twice.
REQ-030 Counter state SHALL be only the two 4-bit digit registers plus the CARRY register; no binary-to-BCD conversion.

Verification
REQ-031 RST=1 for 1 edge, then 10 single-cycle TICKs with EN=1 -> UNI=0, DEZ=1, HEX0=1000000, HEX1=1111001, CARRY never 1.
REQ-032 Preload to 58 via 58 ticks, then 2 ticks -> 59, then 00 with CARRY=1 for exactly one cycle.
REQ-033 At count 23, EN=0 with 5 ticks -> count stays 23; EN=1 with TICK held high 3 cycles -> 26.
REQ-034 At count 59, CLR=1 coincident with TICK=1, EN=1 -> 00 with CARRY=0; RST and CLR together at 37 -> 00.
REQ-035 MAX=99 build: 100 ticks from 00 -> 99 reached, then 00 with one CARRY pulse; digits never exceed 9.
REQ-036 Integration: chain with the 1 Hz divider at 50 MHz, 3 s simulated -> UNI=3, exactly 3 TICK pulses consumed.
